// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with single outstanding imem request and IF/ID register
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stallFE,
    input  logic        stallID,
    input  logic        pcSrcID,
    input  logic [31:0] branchTargetID,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemValid,
    input  logic [31:0] imemData,
    output logic [31:0] instrID,
    output logic [31:0] pcPlus4ID,
    output logic        validID,
    output logic [31:0] pcFE
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      state;
    state_t      nextState;
    logic [31:0] pcReg;
    logic [31:0] reqAddr;
    logic [31:0] bufWord;
    logic [31:0] instrReg;
    logic [31:0] pc4Reg;
    logic        validReg;
    logic        discard;

    logic        stall;
    logic        redirect;
    logic        issue;
    logic        deliver;
    logic        capture;
    logic        nextDiscard;
    logic [31:0] deliverWord;
    logic [31:0] pcPlus4;

    // Both hazard stalls freeze the front end identically; a redirect only counts when not stalled.
    assign stall    = stallFE | stallID;
    assign redirect = pcSrcID & ~stall;
    assign pcPlus4  = pcReg + 32'd4;

    // Next-state, request issue and delivery decisions.
    always_comb begin
        nextState   = state;
        nextDiscard = discard;
        issue       = 1'b0;
        deliver     = 1'b0;
        capture     = 1'b0;
        deliverWord = imemData;
        case (state)
            FETCH: begin
                if (!stall && !pcSrcID) begin
                    issue     = 1'b1;
                    nextState = WAIT;
                end
            end
            WAIT: begin
                if (imemValid) begin
                    if (discard || redirect) begin
                        nextDiscard = 1'b0;
                        nextState   = FETCH;
                    end else if (stall) begin
                        capture   = 1'b1;
                        nextState = HOLD;
                    end else begin
                        deliver   = 1'b1;
                        nextState = FETCH;
                    end
                end else if (redirect) begin
                    nextDiscard = 1'b1;
                end
            end
            HOLD: begin
                if (redirect) begin
                    nextState = FETCH;
                end else if (!stall) begin
                    deliver     = 1'b1;
                    deliverWord = bufWord;
                    nextState   = FETCH;
                end
            end
            default: begin
                nextState = FETCH;
            end
        endcase
    end

    // The request address is latched at issue so a redirect during WAIT cannot disturb it.
    assign imemReq   = issue & ~reset;
    assign imemAddr  = (state == FETCH) ? pcReg : reqAddr;
    assign instrID   = instrReg;
    assign pcPlus4ID = pc4Reg;
    assign validID   = validReg;
    assign pcFE      = pcReg;

    // State, PC, request/buffer registers and the IF/ID register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FETCH;
            discard  <= 1'b0;
            pcReg    <= RESET_PC;
            reqAddr  <= RESET_PC;
            bufWord  <= 32'd0;
            instrReg <= 32'd0;
            pc4Reg   <= 32'd0;
            validReg <= 1'b0;
        end else begin
            state   <= nextState;
            discard <= nextDiscard;
            if (issue) begin
                reqAddr <= pcReg;
            end
            if (capture) begin
                bufWord <= imemData;
            end
            if (redirect) begin
                pcReg <= {branchTargetID[31:2], 2'b00};
            end else if (deliver) begin
                pcReg <= pcPlus4;
            end
            if (!stall) begin
                if (deliver) begin
                    instrReg <= deliverWord;
                    pc4Reg   <= pcPlus4;
                    validReg <= 1'b1;
                end else begin
                    instrReg <= 32'd0;
                    pc4Reg   <= 32'd0;
                    validReg <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - randomized model-checked bench for fetch_stage
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h00000000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stallFE = 1'b0;
    logic        stallID = 1'b0;
    logic        pcSrcID = 1'b0;
    logic [31:0] branchTargetID = 32'd0;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemValid = 1'b0;
    logic [31:0] imemData = 32'd0;
    logic [31:0] instrID;
    logic [31:0] pcPlus4ID;
    logic        validID;
    logic [31:0] pcFE;

    fetch_stage #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .reset(reset), .stallFE(stallFE), .stallID(stallID),
        .pcSrcID(pcSrcID), .branchTargetID(branchTargetID),
        .imemReq(imemReq), .imemAddr(imemAddr), .imemValid(imemValid), .imemData(imemData),
        .instrID(instrID), .pcPlus4ID(pcPlus4ID), .validID(validID), .pcFE(pcFE)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nFail = 0;

    // Memory environment: one slot, response after `lat` cycles.
    int          lat = 1;
    bit          memPending = 0;
    int          memCount = 0;
    logic [31:0] memAddr = 32'd0;

    // Model: outstanding request, captured word, IF/ID contents.
    logic [31:0] mPc = RST_PC;
    bit          mOut = 0;
    logic [31:0] mOutAddr = 32'd0;
    bit          mDisc = 0;
    bit          mHave = 0;
    logic [31:0] mWord = 32'd0;
    logic [31:0] mI = 32'd0;
    logic [31:0] mP = 32'd0;
    bit          mV = 0;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E3779B9) ^ 32'h20080005;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs against the model, advance the model.
    task automatic step(input bit r, input bit sfe, input bit sid, input bit br, input logic [31:0] tg);
        bit          stall;
        bit          expReq;
        bit          got;
        logic [31:0] w;
        @(posedge clk);
        #1;
        reset = r; stallFE = sfe; stallID = sid; pcSrcID = br; branchTargetID = tg;
        imemValid = 1'b0;
        imemData = $urandom;
        if (memPending) begin
            memCount--;
            if (memCount == 0) begin
                imemValid = 1'b1;
                imemData = memWord(memAddr);
                memPending = 0;
            end
        end else if (!mOut && ($urandom_range(0, 9) == 0)) begin
            imemValid = 1'b1;
        end
        #3;
        stall = sfe | sid;
        expReq = !r && !mOut && !mHave && !stall && !br;
        chk("imemReq", {31'd0, imemReq}, {31'd0, expReq});
        if (!r) begin
            chk("pcFE", pcFE, mPc);
            chk("instrID", instrID, mI);
            chk("pcPlus4ID", pcPlus4ID, mP);
            chk("validID", {31'd0, validID}, {31'd0, mV});
            if (mOut) chk("imemAddrHeld", imemAddr, mOutAddr);
            if (expReq) chk("imemAddr", imemAddr, mPc);
        end
        if (imemReq && !r) begin
            memPending = 1;
            memCount = lat;
            memAddr = imemAddr;
        end
        if (r) begin
            mPc = RST_PC; mOut = 0; mDisc = 0; mHave = 0; mWord = 0;
            mI = 0; mP = 0; mV = 0;
        end else begin
            got = 0;
            w = 32'd0;
            if (mOut && imemValid) begin
                mOut = 0;
                if (mDisc || (!stall && br)) mDisc = 0;
                else if (stall) begin mHave = 1; mWord = imemData; end
                else begin got = 1; w = imemData; end
            end else if (mOut && !stall && br) begin
                mDisc = 1;
            end else if (mHave && !stall) begin
                mHave = 0;
                if (!br) begin got = 1; w = mWord; end
            end
            if (expReq) begin mOut = 1; mOutAddr = mPc; end
            if (!stall) begin
                if (br) begin
                    mPc = {tg[31:2], 2'b00}; mI = 0; mP = 0; mV = 0;
                end else if (got) begin
                    mI = w; mP = mPc + 32'd4; mV = 1; mPc = mPc + 32'd4;
                end else begin
                    mI = 0; mP = 0; mV = 0;
                end
            end
        end
    endtask

    initial begin
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        // Latency 1 from reset
        lat = 1;
        step(0, 0, 0, 0, 0);
        chk("lit first req", {31'd0, imemReq}, 32'd1);
        chk("lit first addr", imemAddr, 32'h0);
        step(0, 0, 0, 0, 0);
        lat = 3;
        step(0, 0, 0, 0, 0);
        chk("lit instr0", instrID, 32'h20080005);
        chk("lit pc4 0", pcPlus4ID, 32'h4);
        chk("lit valid0", {31'd0, validID}, 32'd1);
        chk("lit next addr", imemAddr, 32'h4);
        // Latency 3: address held, bubbles
        step(0, 0, 0, 0, 0);
        chk("lit lat3 bubble a", {31'd0, validID}, 32'd0);
        chk("lit lat3 addr a", imemAddr, 32'h4);
        step(0, 0, 0, 0, 0);
        chk("lit lat3 bubble b", {31'd0, validID}, 32'd0);
        chk("lit lat3 addr b", imemAddr, 32'h4);
        step(0, 0, 0, 0, 0);
        chk("lit lat3 addr c", imemAddr, 32'h4);
        step(0, 0, 0, 0, 0);
        chk("lit lat3 instr", instrID, memWord(32'h4));
        chk("lit lat3 pc4", pcPlus4ID, 32'h8);
        // stallID while response arrives, then release
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("lit hold pcFE", pcFE, 32'h8);
        chk("lit hold noreq", {31'd0, imemReq}, 32'd0);
        step(0, 0, 0, 0, 0);
        chk("lit hold instr", instrID, memWord(32'h8));
        chk("lit hold pc4", pcPlus4ID, 32'hC);
        chk("lit hold pcFE adv", pcFE, 32'hC);
        // Redirect to 0x103 while waiting
        step(0, 0, 0, 1, 32'h00000103);
        step(0, 0, 0, 0, 0);
        chk("lit redir pcFE", pcFE, 32'h100);
        chk("lit redir addr held", imemAddr, 32'hC);
        step(0, 0, 0, 0, 0);
        lat = 1;
        step(0, 0, 0, 0, 0);
        chk("lit redir req addr", imemAddr, 32'h100);
        chk("lit redir bubble", {31'd0, validID}, 32'd0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        // Redirect under stallFE ignored; then wrap at 0xFFFFFFFC
        step(0, 1, 0, 1, 32'h00000500);
        chk("lit stall noreq", {31'd0, imemReq}, 32'd0);
        step(0, 0, 0, 1, 32'hFFFFFFFF);
        chk("lit stall pc kept", pcFE, 32'h108);
        step(0, 0, 0, 0, 0);
        chk("lit wrap addr", imemAddr, 32'hFFFFFFFC);
        step(0, 0, 0, 0, 0);
        lat = 3;
        step(0, 0, 0, 0, 0);
        chk("lit wrap pc4", pcPlus4ID, 32'h0);
        chk("lit wrap pcFE", pcFE, 32'h0);
        chk("lit wrap next addr", imemAddr, 32'h0);
        // Reset during WAIT, late response dropped
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        lat = 1;
        step(0, 0, 0, 0, 0);
        chk("lit rst req", {31'd0, imemReq}, 32'd1);
        chk("lit rst addr", imemAddr, RST_PC);
        chk("lit rst late drop", {31'd0, validID}, 32'd0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("lit rst first instr", instrID, memWord(RST_PC));
        chk("lit rst first valid", {31'd0, validID}, 32'd1);
        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            bit r;
            lat = $urandom_range(1, 4);
            r = ($urandom_range(0, 199) == 0) && (!memPending || memCount <= 2);
            step(r, $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 11) == 0, $urandom);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
